// File: rtl/cpu_bus_ctrl_if.sv
// cpu_bus_ctrl_if -- CPU-side bus bundle for cpu_bus_ctrl.
//   master modport: the bus controller (drives phi2, rdy, selects, strobes).
//   slave  modport: the CPU / system side (drives address, rwb, halt, io_ready).
// Signals:
//   cpu_addr[15:0], cpu_rwb (1 = read), halt_req, io_ready   -> controller
//   cpu_phi2, cpu_rdy, ram_cs, rom_cs, io_cs, ram_we,
//   data_oe, timeout                                          <- controller
interface cpu_bus_ctrl_if;
  logic [15:0] cpu_addr;
  logic        cpu_rwb;
  logic        halt_req;
  logic        io_ready;
  logic        cpu_phi2;
  logic        cpu_rdy;
  logic        ram_cs;
  logic        rom_cs;
  logic        io_cs;
  logic        ram_we;
  logic        data_oe;
  logic        timeout;

  modport master (
    input  cpu_addr, cpu_rwb, halt_req, io_ready,
    output cpu_phi2, cpu_rdy, ram_cs, rom_cs, io_cs, ram_we, data_oe, timeout
  );

  modport slave (
    output cpu_addr, cpu_rwb, halt_req, io_ready,
    input  cpu_phi2, cpu_rdy, ram_cs, rom_cs, io_cs, ram_we, data_oe, timeout
  );
endinterface

// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl -- generates the CPU phi2 clock from clk, decodes the address
// into latched RAM/ROM/IO selects for the phi2-high phase, stretches the high
// phase while a slow I/O device is not ready, and drives the CPU RDY line.
// Parameters:
//   DIV         : half-period of cpu_phi2 in clk cycles (2..15)
//   MAX_STRETCH : max extra clk cycles the high phase may be stretched
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : cpu_bus_ctrl_if.master (see interface file)
//   state_dbg   : current FSM state (0 = PHI1, 1 = PHI2, 2 = STRETCH)
//
// I/O handshake: io_cs acts as the request and stays asserted for the whole
// high phase; io_ready is the completion. io_ready is only looked at on the
// last normal high clk and on each STRETCH clk; the access completes on the
// first of those edges where io_ready is 1, and phi2 falls on that edge.
module cpu_bus_ctrl #(
  parameter int DIV         = 5,
  parameter int MAX_STRETCH = 32
) (
  input  logic              clk,
  input  logic              rst,
  cpu_bus_ctrl_if.master    bus,
  output logic [1:0]        state_dbg
);

  localparam int SW = (MAX_STRETCH > 1) ? $clog2(MAX_STRETCH) : 1;
  localparam logic [3:0]    PH_LAST = 4'(DIV - 1);
  localparam logic [3:0]    PH_WE   = 4'(DIV - 2);
  localparam logic [SW-1:0] ST_LAST = SW'(MAX_STRETCH - 1);

  typedef enum logic [1:0] {
    PHI1    = 2'd0,
    PHI2    = 2'd1,
    STRETCH = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    ph_cnt;
  logic [SW-1:0] st_cnt;
  logic          rwb_q;

  // Address decode, sampled into the chip selects when phi2 rises.
  logic dec_ram, dec_io, dec_rom;
  assign dec_ram = ~bus.cpu_addr[15];
  assign dec_io  = (bus.cpu_addr[15:8] == 8'h80);
  assign dec_rom = bus.cpu_addr[15] & ~dec_io;

  // The low address byte takes no part in decode.
  logic addr_lo_unused;
  assign addr_lo_unused = ^bus.cpu_addr[7:0];

  logic hi_done, io_wait, st_done, go_low;
  assign hi_done = (state == PHI2) && (ph_cnt == PH_LAST);
  assign io_wait = bus.io_cs & ~bus.io_ready;
  assign st_done = (state == STRETCH) && (bus.io_ready || (st_cnt == ST_LAST));
  // phi2 falls on this edge.
  assign go_low  = (hi_done && !io_wait) || st_done;

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= PHI1;
      ph_cnt       <= '0;
      st_cnt       <= '0;
      rwb_q        <= 1'b0;
      bus.cpu_phi2 <= 1'b0;
      bus.cpu_rdy  <= 1'b0;
      bus.ram_cs   <= 1'b0;
      bus.rom_cs   <= 1'b0;
      bus.io_cs    <= 1'b0;
      bus.ram_we   <= 1'b0;
      bus.data_oe  <= 1'b0;
      bus.timeout  <= 1'b0;
    end else begin
      bus.ram_we <= 1'b0;
      case (state)
        PHI1: begin
          if (ph_cnt == PH_LAST) begin
            ph_cnt       <= '0;
            state        <= PHI2;
            bus.cpu_phi2 <= 1'b1;
            bus.ram_cs   <= dec_ram;
            bus.rom_cs   <= dec_rom;
            bus.io_cs    <= dec_io;
            rwb_q        <= bus.cpu_rwb;
            // Exactly one select is set, so the OR of selects is 1 here.
            bus.data_oe  <= bus.cpu_rwb;
          end else begin
            ph_cnt <= ph_cnt + 4'd1;
          end
        end
        PHI2: begin
          if (hi_done) begin
            ph_cnt <= '0;
            if (io_wait) begin
              state  <= STRETCH;
              st_cnt <= '0;
            end
          end else begin
            ph_cnt <= ph_cnt + 4'd1;
            // RAM accesses are never stretched, so the last high clk is
            // the one following count DIV-2.
            if ((ph_cnt == PH_WE) && bus.ram_cs && !rwb_q) begin
              bus.ram_we <= 1'b1;
            end
          end
        end
        STRETCH: begin
          if (!st_done) begin
            st_cnt <= st_cnt + SW'(1);
          end else if (!bus.io_ready) begin
            bus.timeout <= 1'b1;
          end
        end
        default: state <= PHI1;
      endcase

      if (go_low) begin
        state        <= PHI1;
        bus.cpu_phi2 <= 1'b0;
        bus.ram_cs   <= 1'b0;
        bus.rom_cs   <= 1'b0;
        bus.io_cs    <= 1'b0;
        bus.data_oe  <= 1'b0;
        // RDY only moves on PHI1 entry, so short halt pulses are ignored.
        bus.cpu_rdy  <= ~bus.halt_req;
      end
    end
  end

endmodule

// File: doc/cpu_bus_ctrl.md
CPU_BUS_CTRL -- requirements
Module: cpu_bus_ctrl

Interface
REQ-001 Parameter DIV, default 5: half-period of cpu_phi2, in clk cycles; legal range 2..15.
REQ-002 Parameter MAX_STRETCH, default 32: maximum number of extra clk cycles the phi2-high phase may be stretched by.
REQ-003 clk  input  1  system clock; every register in the block is clocked on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cpu_addr  input  16  CPU address bus.
REQ-006 cpu_rwb  input  1  CPU read/write (1 = read).
REQ-007 halt_req  input  1  request from another block to stall the CPU.
REQ-008 io_ready  input  1  I/O device ready for the current access.
REQ-009 cpu_phi2  output  1  CPU clock.
REQ-010 cpu_rdy  output  1  CPU RDY line.
REQ-011 ram_cs, rom_cs, io_cs  output  1 each  latched chip selects.
REQ-012 ram_we  output  1  RAM write strobe.
REQ-013 data_oe  output  1  FPGA drives the CPU data bus.
REQ-014 timeout  output  1  sticky flag: a stretch hit MAX_STRETCH.

Function
REQ-015 FSM states: PHI1 (phi2 low), PHI2 (phi2 high), STRETCH (phi2 held high past its normal length).
REQ-016 A 4-bit phase counter counts 0..DIV-1 in PHI1 and PHI2.
- At terminal count in PHI1: counter clears, state goes to PHI2, cpu_phi2 goes to 1.
REQ-017 Decode is sampled on the same clk edge as the PHI1->PHI2 transition and held for the whole high phase:
- ram_cs = (cpu_addr[15] == 0)
- io_cs = (cpu_addr[15:8] == 8'h80)
- rom_cs = cpu_addr[15] & ~io_cs
- exactly one select is 1 during PHI2/STRETCH; all are 0 during PHI1.
REQ-018 At terminal count in PHI2:
- if io_cs & ~io_ready, go to STRETCH and clear the stretch counter;
- otherwise clear the counter, go to PHI1, and set cpu_phi2 to 0.
REQ-019 STRETCH keeps cpu_phi2 at 1 and increments the stretch counter every clk.
- It exits to PHI1 (phi2 to 0) on the first clk where io_ready == 1, or when the counter reaches MAX_STRETCH-1.
- A forced exit at MAX_STRETCH-1 sets timeout.
REQ-020 ram_we is a single-clk pulse, asserted in the last clk of the high phase (the cycle before phi2 falls) when ram_cs & ~cpu_rwb; it is never asserted for rom_cs or io_cs.
REQ-021 data_oe = cpu_rwb & (PHI2 or STRETCH) & (ram_cs | rom_cs | io_cs), registered.
REQ-022 cpu_rdy changes only on the clk edge entering PHI1:
- it takes the value ~halt_req sampled then;
- a halt_req pulse that starts and ends within one phi2 period has no effect.
REQ-023 timeout stays set until rst; it does not stop the clocking.
REQ-024 Register widths must be sized so no counter wraps before its terminal compare; a DIV change requires reset.

Reset
REQ-025 While rst is 1 and after its release:
- cpu_phi2 = 0, state = PHI1, counters = 0
- ram_cs = rom_cs = io_cs = 0
- ram_we = 0, data_oe = 0, timeout = 0
- cpu_rdy = 0
REQ-026 The first PHI1 after rst release is a full DIV clks; cpu_rdy follows REQ-022 from the first PHI1 entry after that.
REQ-027 rst asserted during PHI2 or STRETCH immediately forces the REQ-025 values, including phi2 = 0, with no ram_we pulse.

Verification
REQ-028 DIV=5, no I/O accesses, halt_req=0:
- cpu_phi2 period = 10 clk, 50% duty;
- cpu_rdy = 1 from the second PHI1.
REQ-029 Write to addr 0x1234 (rwb=0):
- ram_cs = 1 for the 5-clk high phase;
- exactly one ram_we pulse, in the 5th high clk;
- data_oe = 0 throughout.
REQ-030 Read of 0x8010 with io_ready low for 7 clk after the PHI2 terminal count:
- phi2 high phase = 12 clk;
- io_cs = 1 and data_oe = 1 throughout the high phase;
- timeout = 0.
REQ-031 Read of 0x8000 with io_ready held 0:
- high phase = 5 + 32 clk;
- timeout = 1 and stays 1;
- the next access, to 0xFFFC, gives rom_cs = 1 with a normal 5-clk high phase.
REQ-032 halt_req raised mid-PHI2 and held for 3 periods:
- cpu_rdy falls at the next PHI1 entry;
- cpu_rdy rises at the first PHI1 entry after halt_req drops;
- a 2-clk halt_req pulse inside PHI2 leaves cpu_rdy = 1.
REQ-033 rst asserted during a STRETCH on an I/O access:
- all outputs take the REQ-025 values asynchronously;
- after release, normal 10-clk periods resume.
